// File: rtl/div_pkg.sv
// Shared types and helpers for the radix-4 sequential divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIX,
        DONE
    } state_t;

    localparam int DIGIT_BITS = 2;

    // Widest operand the helper below supports; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    // Two's-complement magnitude / conditional negate, modulo 2^MAX_W.
    function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_r4_seq_if.sv
// Request/response bundle between the execute stage and the radix-4 divider.
interface div_r4_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic         x_signed;
    logic         y_signed;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ready;
    logic         valid;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;

    modport master (
        output start, x_signed, y_signed, x, y,
        input  ready, valid, q, r, dz
    );

    modport slave (
        input  start, x_signed, y_signed, x, y,
        output ready, valid, q, r, dz
    );
endinterface

// File: rtl/div_r4_digit.sv
// Radix-4 digit selection: picks the largest multiple of ay not exceeding pr.
module div_r4_digit
    import div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W+1:0]            pr,
    input  logic [W-1:0]            ay,
    input  logic [W+1:0]            ay3,
    output logic [DIGIT_BITS-1:0]   d,
    output logic [W+1:0]            pr_next
);

    logic [W+1:0] ay1;
    logic [W+1:0] ay2;

    assign ay1 = {2'b00, ay};
    assign ay2 = {1'b0, ay, 1'b0};

    always_comb begin
        if (pr >= ay3) begin
            d       = DIGIT_BITS'(3);
            pr_next = pr - ay3;
        end else if (pr >= ay2) begin
            d       = DIGIT_BITS'(2);
            pr_next = pr - ay2;
        end else if (pr >= ay1) begin
            d       = DIGIT_BITS'(1);
            pr_next = pr - ay1;
        end else begin
            d       = DIGIT_BITS'(0);
            pr_next = pr;
        end
    end

endmodule

// File: rtl/div_r4_seq.sv
// Iterative radix-4 signed/unsigned divider with RISC-V divide-by-zero/overflow results.
// Define DIV_EARLY_OUT_EN to skip leading zero digit pairs of the dividend.
module div_r4_seq
    import div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset,
    div_r4_seq_if.slave   bus
);

    localparam int CW = $clog2(W/2 + 1);

    state_t state, state_nx;

    logic          ready, valid;
    logic [W-1:0]  x_l, y_l;
    logic          xs_l, ys_l;
    logic [W-1:0]  ax, ay, q_acc;
    logic [W+1:0]  ay3, pr;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r;
    logic [W-1:0]  q_r, r_r;
    logic          dz_r;

    logic          x_neg, y_neg;
    logic [W-1:0]  ax_n, ay_n, ax_init;
    logic [W+1:0]  ay3_n;
    logic [CW-1:0] cnt_init;
    logic [W+1:0]  pr_shift, pr_next;
    logic [DIGIT_BITS-1:0] d;
    logic [W-1:0]  q_fix, r_fix;

    // Operand conditioning, evaluated from the latched request during SETUP.
    assign x_neg = xs_l & x_l[W-1];
    assign y_neg = ys_l & y_l[W-1];
    assign ax_n  = W'(twos_abs(MAX_W'(x_l), x_neg));
    assign ay_n  = W'(twos_abs(MAX_W'(y_l), y_neg));
    assign ay3_n = {2'b00, ay_n} + {1'b0, ay_n, 1'b0};

`ifdef DIV_EARLY_OUT_EN
    localparam int LZW = $clog2(W + 1);

    logic [LZW-1:0] lz;
    logic [CW-1:0]  lz_pairs;

    always_comb begin
        lz = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (ax_n[i]) lz = LZW'(W - 1 - i);
        end
    end

    assign lz_pairs = CW'(lz >> 1);
    assign ax_init  = ax_n << {lz_pairs, 1'b0};
    // A zero dividend still runs one iteration so the FSM path is uniform.
    assign cnt_init = (lz_pairs == CW'(W/2)) ? CW'(1) : CW'(W/2) - lz_pairs;
`else
    assign ax_init  = ax_n;
    assign cnt_init = CW'(W/2);
`endif

    assign pr_shift = {pr[W-1:0], ax[W-1 -: DIGIT_BITS]};

    div_r4_digit #(.W(W)) u_digit (
        .pr      (pr_shift),
        .ay      (ay),
        .ay3     (ay3),
        .d       (d),
        .pr_next (pr_next)
    );

    assign q_fix = dz_r ? '1  : W'(twos_abs(MAX_W'(q_acc), neg_q));
    assign r_fix = dz_r ? x_l : W'(twos_abs(MAX_W'(pr[W-1:0]), neg_r));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        // NOTE: default first so every path assigns state_nx; otherwise a latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SETUP;
            SETUP:   state_nx = (y_l == '0) ? FIX : ITER;
            ITER:    if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = (state == IDLE);
        valid = (state == DONE);
    end

    // Architecturally visible results: reset, and held between operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r  <= '0;
            r_r  <= '0;
            dz_r <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (bus.start) dz_r <= 1'b0;
                SETUP: if (y_l == '0) dz_r <= 1'b1;
                FIX: begin
                    q_r <= q_fix;
                    r_r <= r_fix;
                end
                default: ;
            endcase
        end
    end

    // NOTE: working registers are not reset; each is loaded before it is read.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (bus.start) begin
                    x_l  <= bus.x;
                    y_l  <= bus.y;
                    xs_l <= bus.x_signed;
                    ys_l <= bus.y_signed;
                end
            end
            SETUP: begin
                ax    <= ax_init;
                ay    <= ay_n;
                ay3   <= ay3_n;
                neg_q <= x_neg ^ y_neg;
                neg_r <= x_neg;
                pr    <= '0;
                q_acc <= '0;
                cnt   <= cnt_init;
            end
            ITER: begin
                ax    <= ax << DIGIT_BITS;
                pr    <= pr_next;
                q_acc <= {q_acc[W-DIGIT_BITS-1:0], d};
                cnt   <= cnt - CW'(1);
            end
            default: ;
        endcase
    end

    assign bus.ready = ready;
    assign bus.valid = valid;
    assign bus.q     = q_r;
    assign bus.r     = r_r;
    assign bus.dz    = dz_r;

endmodule

// File: tb/tb_div_r4_seq.sv
// Directed self-checking bench for div_r4_seq (W=32, default fixed-latency build).
module tb_div_r4_seq;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    div_r4_seq_if #(.W(32)) bus ();

    div_r4_seq #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        xs, ys;
        logic [31:0] x, y, q, r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request and take the accept edge; returns #1 after that edge.
    task automatic accept(input string tag, input logic xs, input logic ys,
                          input logic [31:0] x, input logic [31:0] y);
        bus.x_signed = xs;
        bus.y_signed = ys;
        bus.x        = x;
        bus.y        = y;
        bus.start    = 1'b1;
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_result(input string tag, input int lat, input logic [31:0] eq,
                               input logic [31:0] er, input logic edz);
        int cyc = 1;
        while (bus.valid !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_q"}, bus.q, eq);
        check({tag, "_r"}, bus.r, er);
        check({tag, "_dz"}, 32'(bus.dz), 32'(edz));
    endtask

    task automatic run_op(input vec_t v);
        accept(v.tag, v.xs, v.ys, v.x, v.y);
        bus.start = 1'b0;
        wait_result(v.tag, v.lat, v.q, v.r, v.dz);
        @(posedge clk);
        #1;
        check({v.tag, "_pulse"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int saw_valid;

        vecs[0] = '{"u100_7",   1'b0, 1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0, 19};
        vecs[1] = '{"sm7_2",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 19};
        vecs[2] = '{"s7_m2",    1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 19};
        vecs[3] = '{"ovf",      1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0, 19};
        vecs[4] = '{"umax_1",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 19};
        vecs[5] = '{"mixed",    1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 19};
        vecs[6] = '{"ubig",     1'b0, 1'b0, 32'd1000000007, 32'd12345,   32'h0001_3C6C, 32'h0000_15FB, 1'b0, 19};
        vecs[7] = '{"dz",       1'b0, 1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 3};

        // start held high during reset must not be taken
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.x_signed = 1'b0;
        bus.y_signed = 1'b0;
        bus.x        = 32'd9;
        bus.y        = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_q",     bus.q, 32'd0);
        check("rst_r",     bus.r, 32'd0);
        check("rst_dz",    32'(bus.dz), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // start held through a divide-by-zero op, then back-to-back accept
        accept("hold", 1'b0, 1'b0, 32'h1234_5678, 32'd0);
        bus.x = 32'd45;
        bus.y = 32'd6;
        wait_result("hold", 3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_ready", 32'(bus.ready), 32'd1);
        check("b2b_valid", 32'(bus.valid), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_dz_clr", 32'(bus.dz), 32'd0);
        wait_result("b2b", 19, 32'd7, 32'd3, 1'b0);
        @(posedge clk);
        #1;

        // reset at accept+8 aborts silently
        accept("abort", 1'b0, 1'b0, 32'd1000, 32'd7);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_q",     bus.q, 32'd0);
        check("abort_r",     bus.r, 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        saw_valid = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) saw_valid = 1;
        end
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        run_op('{"u15_4", 1'b0, 1'b0, 32'd15, 32'd4, 32'd3, 32'd3, 1'b0, 19});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
